// File: rtl/mem_sequencer.sv
// mem_sequencer: steps a CPU core through FETCH -> DECODE -> [DATA] -> EXEC
// over a single-port memory with a ready handshake, a wait-cycle timeout,
// a halt park state and a retired-instruction counter.
module mem_sequencer #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_pc,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_out,
    input  logic        cpu_write,
    input  logic        cpu_dacc,
    input  logic        halt,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] instruction,
    output logic [15:0] data,
    output logic        cpu_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        halted,
    output logic        err,
    output logic [15:0] instr_count
);

    localparam int unsigned WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        DATA,
        EXEC,
        HALTED,
        ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   instruction_q, instruction_d;
    logic [15:0]   data_q, data_d;
    logic [15:0]   instr_count_q, instr_count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          wait_limit;

    // One more stalled cycle at this count means the memory has used up its budget.
    assign wait_limit = (wait_q == WW'(WAIT_MAX - 1));

    // State and datapath registers; reset is synchronous and active low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH;
            instruction_q <= '0;
            data_q        <= '0;
            instr_count_q <= '0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            data_q        <= data_d;
            instr_count_q <= instr_count_d;
            wait_q        <= wait_d;
        end
    end

    // Next-state and register-update logic; the wait counter is zero everywhere except during a stalled transfer.
    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        data_d        = data_q;
        instr_count_d = instr_count_q;
        wait_d        = '0;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    instruction_d = mem_rdata;
                    state_d       = DECODE;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_limit) state_d = ERROR;
                end
            end
            DECODE: begin
                state_d = cpu_dacc ? DATA : EXEC;
            end
            DATA: begin
                if (mem_ready) begin
                    if (!cpu_write) data_d = mem_rdata;
                    state_d = EXEC;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_limit) state_d = ERROR;
                end
            end
            EXEC: begin
                instr_count_d = instr_count_q + 16'd1;
                state_d       = halt ? HALTED : FETCH;
            end
            HALTED: begin
                if (!halt) state_d = FETCH;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // Bus, step and status outputs decoded from the current state, held low while reset is asserted.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_en    = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = cpu_pc;
                end
                DATA: begin
                    mem_req   = 1'b1;
                    mem_we    = cpu_write;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_out;
                end
                EXEC:    cpu_en = 1'b1;
                HALTED:  halted = 1'b1;
                ERROR:   err    = 1'b1;
                default: ;
            endcase
        end
    end

    assign instruction = instruction_q;
    assign data        = data_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Testbench for mem_sequencer: the bench plays CPU and memory, queues the
// expected bus transfers and CPU steps, and a monitor checks them as they appear.
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_pc, cpu_addr, cpu_out;
    logic        cpu_write, cpu_dacc, halt;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] instruction, data, mem_addr, mem_wdata, instr_count;
    logic        cpu_en, mem_req, mem_we, halted, err;

    mem_sequencer #(.WAIT_MAX(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_pc      (cpu_pc),
        .cpu_addr    (cpu_addr),
        .cpu_out     (cpu_out),
        .cpu_write   (cpu_write),
        .cpu_dacc    (cpu_dacc),
        .halt        (halt),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .instruction (instruction),
        .data        (data),
        .cpu_en      (cpu_en),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } mem_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] data;
        logic [15:0] count;
        logic [7:0]  cycles;
    } exec_t;

    mem_t        mem_q[$];
    exec_t       exec_q[$];
    int unsigned wait_tq[$];
    logic [15:0] mem_arr [0:15];
    logic [15:0] exp_data;
    logic [15:0] exp_count;
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: waits the queued number of cycles per transfer, then answers from mem_arr.
    initial begin
        bit          busy = 0;
        int unsigned wcnt = 0;
        int unsigned wtarget = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset || !mem_req) begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
                if (!reset) busy = 0;
            end else begin
                if (!busy) begin
                    busy    = 1;
                    wcnt    = 0;
                    wtarget = (wait_tq.size() > 0) ? wait_tq.pop_front() : 0;
                end
                if (wcnt == wtarget) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_arr[mem_addr[3:0]];
                    if (mem_we) mem_arr[mem_addr[3:0]] = mem_wdata;
                    busy = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 16'($urandom);
                    wcnt++;
                end
            end
        end
    end

    // Monitor: checks every bus cycle against the queued transfer and every CPU step against the queued result.
    always @(negedge clk) begin
        if (!reset) begin
            cyc = 0;
        end else begin
            if (!halted && !err) cyc++;
            if (mem_req) begin
                check("mem_expected", 64'(mem_q.size() != 0), 64'd1);
                if (mem_q.size() != 0) begin
                    check("mem_addr", mem_addr, mem_q[0].addr);
                    check("mem_we", mem_we, mem_q[0].we);
                    check("mem_wdata", mem_wdata, mem_q[0].wdata);
                    if (mem_ready) void'(mem_q.pop_front());
                end
            end else begin
                check("idle_bus", {mem_we, mem_addr, mem_wdata}, 64'd0);
            end
            if (cpu_en) begin
                check("exec_expected", 64'(exec_q.size() != 0), 64'd1);
                check("exec_no_req", mem_req, 0);
                if (exec_q.size() != 0) begin
                    exec_t x;
                    x = exec_q.pop_front();
                    check("instruction", instruction, x.instr);
                    check("data", data, x.data);
                    check("instr_count", instr_count, x.count);
                    check("exec_cycles", cyc, x.cycles);
                end
                cyc = 0;
            end
        end
    end

    // Issues one instruction from the current FETCH cycle and returns one cycle after its EXEC (FETCH again).
    task automatic run_instr(input logic [15:0] pc, input logic [15:0] addr, input logic [15:0] out,
                             input logic dacc, input logic wr, input logic hlt,
                             input int unsigned fw, input int unsigned dw);
        mem_t        m;
        exec_t       x;
        bit          seen;
        int unsigned k;
        m.addr = pc; m.we = 1'b0; m.wdata = '0;
        mem_q.push_back(m);
        wait_tq.push_back(fw);
        if (dacc) begin
            m.addr = addr; m.we = wr; m.wdata = out;
            mem_q.push_back(m);
            wait_tq.push_back(dw);
        end
        x.instr = mem_arr[pc[3:0]];
        if (dacc && !wr) exp_data = mem_arr[addr[3:0]];
        x.data   = exp_data;
        x.count  = exp_count;
        x.cycles = 8'(3 + fw + (dacc ? 1 + dw : 0));
        exec_q.push_back(x);
        cpu_pc = pc; cpu_addr = addr; cpu_out = out;
        cpu_dacc = dacc; cpu_write = wr; halt = hlt;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = cpu_en;
        end
        check("exec_reached", 64'(seen), 64'd1);
        exp_count = exp_count + 16'd1;
        @(posedge clk);
        #1;
        if (hlt) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < int'(k); i++) begin
                check("halted", {halted, mem_req, cpu_en}, 64'b100);
                @(posedge clk);
                #1;
            end
            halt = 1'b0;
            check("halt_hold", halted, 1);
            @(posedge clk);
            #1;
            check("resume_fetch", {halted, mem_req}, 64'b01);
        end
    endtask

    task automatic do_reset(input int unsigned ncyc);
        reset = 1'b0; halt = 1'b0; cpu_dacc = 1'b0; cpu_write = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        mem_q.delete();
        exec_q.delete();
        wait_tq.delete();
        exp_data  = '0;
        exp_count = '0;
        check("rst_regs", {instruction, data, instr_count}, 64'd0);
        check("rst_flags", {err, halted, cpu_en, mem_req, mem_we}, 64'd0);
        check("rst_bus", {mem_addr, mem_wdata}, 64'd0);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_t m;
        int   n;
        cpu_pc = '0; cpu_addr = '0; cpu_out = '0;
        cpu_write = 1'b0; cpu_dacc = 1'b0; halt = 1'b0;
        exp_data = '0; exp_count = '0;
        for (int i = 0; i < 16; i++) mem_arr[i] = 16'($urandom);

        do_reset(3);

        // Zero-wait non-data instructions: 3 cycles each, counter starting at 0.
        mem_arr[0] = 16'h4000;
        for (int i = 0; i < 3; i++) run_instr(16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0);

        // Load from 0x0032 returning 0x0005.
        mem_arr[1] = 16'h1111;
        mem_arr[2] = 16'h0005;
        run_instr(16'h0021, 16'h0032, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0);

        // Store 0x00AA with three stalled cycles; load data must stay 0x0005.
        run_instr(16'h0022, 16'h0037, 16'h00AA, 1'b1, 1'b1, 1'b0, 0, 3);

        // Random instruction mix with random memory stalls and halts.
        for (int i = 0; i < 40; i++) begin
            run_instr(16'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 5) == 0),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Counter preset to 0xFFFF, halt raised from FETCH through DATA: retires, parks, wraps to 0.
        force dut.instr_count_q = 16'hFFFF;
        exp_count = 16'hFFFF;
        fork
            begin
                @(negedge clk);
                @(negedge clk);
                release dut.instr_count_q;
            end
        join_none
        run_instr(16'h0105, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1);
        check("count_wrap", instr_count, 64'h0);

        // One more instruction so data/count are non-zero, then reset during a stalled fetch.
        run_instr(16'h0203, 16'h0044, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 0);
        m.addr = 16'h0300; m.we = 1'b0; m.wdata = '0;
        mem_q.push_back(m);
        wait_tq.push_back(3);
        cpu_pc = 16'h0300; cpu_dacc = 1'b0; halt = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1);

        // First instructions after reset.
        run_instr(16'h0301, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(16'h0302, 16'h0039, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 1);

        // Memory never ready: error after four stalled fetch cycles, sticky until reset.
        m.addr = 16'h1234; m.we = 1'b0; m.wdata = '0;
        mem_q.push_back(m);
        wait_tq.push_back(1000);
        cpu_pc = 16'h1234; cpu_dacc = 1'b0; halt = 1'b0;
        n = 0;
        while (!err && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("err_latency", n, 5);
        for (int i = 0; i < 3; i++) begin
            check("err_sticky", {err, mem_req, cpu_en}, 64'b100);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        do_reset(1);

        run_instr(16'h0400, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0);
        do_reset(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
